// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared widths, IO split and access encodings
// for the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int ADDR_LEN = 32;
  localparam int DATA_LEN = 32;
  localparam logic [31:0] IO_LIM = 32'h30000;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b11
  } mem_len_e;

  typedef enum logic {
    SRC_IF  = 1'b0,
    SRC_LSB = 1'b1
  } src_e;

  typedef struct packed {
    src_e                src;
    logic                wr;
    logic [2:0]          n;
    logic [DATA_LEN-1:0] wdata;
  } xfer_t;

  function automatic logic [2:0] len2n(input logic [1:0] len);
    return {1'b0, len} + 3'd1;
  endfunction

endpackage

// File: rtl/mem_arb.sv
// mem_arb: two-way round-robin grant between IF and LSB,
// remembering the last winner to break ties.
module mem_arb
  import mem_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset_ni,
  input  logic en_i,
  input  logic req_if_i,
  input  logic req_lsb_i,
  output logic gnt_if_o,
  output logic gnt_lsb_o
);

  src_e last_q, last_d;

  // Grant the lone requester, or the one that lost last time.
  always_comb begin
    gnt_if_o  = 1'b0;
    gnt_lsb_o = 1'b0;
    last_d    = last_q;
    if (en_i) begin
      if (req_if_i && req_lsb_i) begin
        gnt_if_o  = (last_q == SRC_LSB);
        gnt_lsb_o = (last_q == SRC_IF);
      end else begin
        gnt_if_o  = req_if_i;
        gnt_lsb_o = req_lsb_i;
      end
    end
    if (gnt_if_o)  last_d = SRC_IF;
    if (gnt_lsb_o) last_d = SRC_LSB;
  end

  // Last-grant register; LSB after reset so IF wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset_ni) last_q <= SRC_LSB;
    else           last_q <= last_d;
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM/IO port owner for IF and LSB.
// Optional MEMCTRL_PERF_EN adds grant/stall counters.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_LEN,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_LIM)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic              clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              lsb_req,
  input  logic              lsb_type,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [1:0]        lsb_len,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_done,
  output logic [31:0]       lsb_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  input  logic              io_buffer_full
`ifdef MEMCTRL_PERF_EN
  ,
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_lsb_grants,
  output logic [31:0]       perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  xfer_t             x_q, x_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        iss_q, iss_d;
  logic              cap_v_q, cap_v_d;
  logic [1:0]        cap_i_q, cap_i_d;
  logic [31:0]       ifd_q, ifd_d;
  logic [31:0]       lsd_q, lsd_d;

  logic gnt_if, gnt_lsb, arb_en;
  logic flush, io_hold, last_rd;
  logic [2:0] a_idx;

  assign arb_en  = ready && (state_q == S_IDLE) && !clear;
  assign flush   = ready && clear;
  assign io_hold = (state_q == S_BUSY) && x_q.wr &&
                   (addr_q >= IO_BASE) && io_buffer_full;
  assign last_rd = cap_v_q && ({1'b0, cap_i_q} == x_q.n - 3'd1);

  mem_arb u_arb (
    .clk       (clk),
    .reset_ni  (reset),
    .en_i      (arb_en),
    .req_if_i  (if_req),
    .req_lsb_i (lsb_req),
    .gnt_if_o  (gnt_if),
    .gnt_lsb_o (gnt_lsb)
  );

  // State and datapath registers; ready=0 holds everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      addr_q  <= '0;
      iss_q   <= '0;
      cap_v_q <= 1'b0;
      cap_i_q <= '0;
      ifd_q   <= '0;
      lsd_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      addr_q  <= addr_d;
      iss_q   <= iss_d;
      cap_v_q <= cap_v_d;
      cap_i_q <= cap_i_d;
      ifd_q   <= ifd_d;
      lsd_q   <= lsd_d;
    end
  end

  // Next state: stores always finish, reads abort on clear.
  always_comb begin
    state_d = state_q;
    if (ready) begin
      unique case (state_q)
        S_IDLE: if (gnt_if || gnt_lsb) state_d = S_BUSY;
        S_BUSY: begin
          if (x_q.wr) begin
            if (!io_hold && (iss_q + 3'd1 == x_q.n))
              state_d = S_DONE;
          end else if (clear) begin
            state_d = S_IDLE;
          end else if (last_rd) begin
            state_d = S_DONE;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Latch on grant, step the byte index, assemble read bytes.
  always_comb begin
    x_d     = x_q;
    addr_d  = addr_q;
    iss_d   = iss_q;
    cap_v_d = cap_v_q;
    cap_i_d = cap_i_q;
    ifd_d   = ifd_q;
    lsd_d   = lsd_q;
    if (ready) begin
      if (state_q == S_IDLE) begin
        if (gnt_if) begin
          x_d.src   = SRC_IF;
          x_d.wr    = 1'b0;
          x_d.n     = 3'd4;
          x_d.wdata = '0;
          addr_d    = if_addr;
          ifd_d     = '0;
        end
        if (gnt_lsb) begin
          x_d.src   = SRC_LSB;
          x_d.wr    = lsb_type;
          x_d.n     = len2n(lsb_len);
          x_d.wdata = lsb_wdata;
          addr_d    = lsb_addr;
          lsd_d     = '0;
        end
        iss_d   = '0;
        cap_v_d = 1'b0;
        cap_i_d = '0;
      end else if (state_q == S_BUSY) begin
        if (x_q.wr) begin
          if (!io_hold) iss_d = iss_q + 3'd1;
        end else if (clear) begin
          cap_v_d = 1'b0;
        end else begin
          if (cap_v_q) begin
            if (x_q.src == SRC_IF)
              ifd_d[{cap_i_q, 3'b000} +: 8] = ram_din;
            else
              lsd_d[{cap_i_q, 3'b000} +: 8] = ram_din;
          end
          cap_v_d = (iss_q < x_q.n);
          cap_i_d = iss_q[1:0];
          if (iss_q < x_q.n) iss_d = iss_q + 3'd1;
        end
      end
    end
  end

  // While frozen, re-present the in-flight read byte's address.
  assign a_idx = (ready || !cap_v_q) ? iss_q : {1'b0, cap_i_q};

  // Port drive and done pulses.
  always_comb begin
    ram_a    = '0;
    ram_dout = '0;
    ram_wr   = 1'b0;
    if_done  = 1'b0;
    lsb_done = 1'b0;
    if (state_q == S_BUSY) begin
      ram_a = addr_q + ADDR_W'(a_idx);
      if (x_q.wr) begin
        ram_dout = x_q.wdata[{iss_q[1:0], 3'b000} +: 8];
        ram_wr   = ready && !io_hold;
      end
    end
    if (state_q == S_DONE) begin
      if_done  = (x_q.src == SRC_IF) && !flush;
      lsb_done = (x_q.src == SRC_LSB) && !(flush && !x_q.wr);
    end
  end

  assign if_data   = ifd_q;
  assign lsb_rdata = lsd_q;

`ifdef MEMCTRL_PERF_EN
  logic [31:0] pif_q, plsb_q, pst_q;

  // Saturating grant and IO-stall counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pif_q  <= '0;
      plsb_q <= '0;
      pst_q  <= '0;
    end else begin
      if (gnt_if && pif_q != '1)   pif_q  <= pif_q + 32'd1;
      if (gnt_lsb && plsb_q != '1) plsb_q <= plsb_q + 32'd1;
      if (ready && io_hold && pst_q != '1)
        pst_q <= pst_q + 32'd1;
    end
  end

  assign perf_if_grants    = pif_q;
  assign perf_lsb_grants   = plsb_q;
  assign perf_stall_cycles = pst_q;
`endif

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Sole owner of the byte-wide RAM/IO port. Arbitrates between instruction fetch (IF) and the load/store buffer (LSB). Serialises each 1/2/4-byte access into single-byte RAM cycles, assembles little-endian read words and stalls IO stores on io_buffer_full. Sits between the core's IF/LSB request interfaces and the top-level ram_* pins.

Parameters:
ADDR_W, 32, address width
IO_BASE, 32'h30000, addresses >= IO_BASE are IO space

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
ready  in  1  global enable; 0 = freeze
clear  in  1  misprediction flush
if_req  in  1  IF request, held until if_done
if_addr  in  32  IF word address
if_done  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched word
lsb_req  in  1  LSB request, held until lsb_done
lsb_type  in  1  0 = load, 1 = store
lsb_addr  in  32  byte address
lsb_len  in  2  00 = 1B, 01 = 2B, 11 = 4B
lsb_wdata  in  32  store data, low bytes used
lsb_done  out  1  one-cycle pulse
lsb_rdata  out  32  load data, zero-extended (LSB extends)
ram_din  in  8  RAM read byte, valid the cycle after ram_a
ram_dout  out  8  write byte
ram_a  out  32  byte address
ram_wr  out  1  1 = write
io_buffer_full  in  1  IO output FIFO full

Behaviour:
- Reset (reset=0 at posedge): state=IDLE, last_grant=LSB. All outputs 0: if_done, lsb_done, ram_wr, ram_a, ram_dout, if_data, lsb_rdata.
- States: IDLE -> BUSY -> DONE -> IDLE. In DONE the done pulse is high and new requests are ignored. This covers the requester's one-cycle-late request drop.
- Arbitration in IDLE:
  - Only one requester pending: grant it.
  - Both pending: grant the one not in last_grant (round-robin).
  - On grant: latch addr, len, type, wdata and n = len+1 (n = 4 for IF). Set idx = 0.
- Read timing (req sampled at end of cycle 0):
  - ram_a = addr+k in cycle k+1.
  - byte k captured from ram_din at end of cycle k+2 into bits [8k+7:8k].
  - done high in cycle n+2; LW/fetch = cycle 6.
- Write timing: ram_wr = 1, ram_a = addr+k, ram_dout = wdata[8k+7:8k] in cycle k+1. done high in cycle n+1.
- IO store stall: if addr >= IO_BASE, type = store and io_buffer_full = 1 at the byte's issue edge, hold with ram_wr = 0. Issue the byte once io_buffer_full = 0.
- IO loads: no stall.
- Address arithmetic is 32-bit wrap; no alignment check.
- ready = 0:
  - All state frozen; ram_wr forced to 0.
  - An in-flight read byte is discarded and its address re-presented after resume.
  - A done pulse pending in DONE extends until the first ready cycle.
- clear = 1:
  - An active fetch or load aborts to IDLE with no done pulse and ram_wr = 0.
  - A store in progress (already committed) is NOT aborted; it completes and pulses lsb_done.
  - A load in DONE has its lsb_done suppressed.
  - No new grant is made in the clear cycle.
- clear and reset together: reset wins.
- Done outputs hold their data until the next grant to that requester.

Optional Feature:
MEMCTRL_PERF_EN:
- Defined: adds outputs perf_if_grants[31:0], perf_lsb_grants[31:0], perf_stall_cycles[31:0]. Stall cycles count IO-full holds.
  - Counters saturate at 32'hFFFFFFFF.
  - Counters are cleared by reset and not by clear.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared def.v holds MEM_LEN encodings (B/H/W), IO_LIM/IO_BASE, and the ADDR_LEN/DATA_LEN ranges.
- Local state encodings live in this module.
- One sub-module is natural: mem_arb (2-way round-robin grant with last_grant register). Serialiser FSM stays in mem_ctrl.

Test Plan:
- LW at 0x100, RAM bytes 11 22 33 44, lsb_req at cycle 0 -> lsb_done in cycle 6, lsb_rdata = 32'h44332211.
- SH addr 0x200, wdata 32'hAABBCCDD -> ram_wr cycles 1-2, writes (0x200, DD) then (0x201, CC); lsb_done cycle 3.
- if_req and lsb_req both high in IDLE with last_grant = LSB -> IF served first, LSB granted the cycle after IF's DONE; repeat -> order alternates.
- SB to 0x30000 with io_buffer_full = 1 for 5 cycles -> ram_wr stays 0 for 5 cycles, then one write of the byte; lsb_done follows.
- clear during byte 2 of a fetch -> no if_done, IDLE next cycle. clear during byte 1 of a committed SW -> all 4 bytes written, lsb_done pulses.
- ready = 0 for 3 cycles mid-LW -> same final lsb_rdata, done delayed exactly 3 cycles, ram_wr = 0 throughout.
